// File: rtl/switch_event_scanner.sv
// switch_event_scanner
// Samples a slide-switch bus, latches one net edge per switch, and a
// round-robin scanner turns pending edges into ordered {index, direction}
// events in a valid/ready FIFO. Also tracks the up-switch count and the
// first-up switch index for downstream mode/conflict logic.
module switch_event_scanner #(
  parameter int NUM_SW     = 10,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_SW-1:0] SW,
  output logic              EVT_VALID,
  input  logic              EVT_READY,
  output logic [IDX_W-1:0]  EVT_IDX,
  output logic              EVT_DIR,
  output logic [CNT_W-1:0]  UP_COUNT,
  output logic [IDX_W-1:0]  FIRST_UP,
  output logic              CONFLICT,
  output logic [IDX_W-1:0]  SCAN_IDX
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IDX_W-1:0] NONE     = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SW - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  // Switch history and edge detection
  logic [NUM_SW-1:0] hist_q;
  logic [NUM_SW-1:0] rise, fall;

  // Per-switch pending edge
  logic [NUM_SW-1:0] pend_v_q, pend_v_d;
  logic [NUM_SW-1:0] pend_dir_q, pend_dir_d;

  // Scanner
  logic [IDX_W-1:0] scan_q, scan_d;
  logic             push, push_dir;

  // Event FIFO
  logic [IDX_W:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, pop;
  logic [IDX_W:0]   head;

  // Up tracking
  logic [CNT_W-1:0] up_cnt_q, up_cnt_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [CNT_W-1:0] sw_pop;

  // Edge detect against the previous sample
  always_comb begin
    rise = SW & ~hist_q;
    fall = ~SW & hist_q;
  end

  // Scanner advance and push decision; a pop at full frees the slot this cycle
  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = EVT_VALID && EVT_READY;
    push     = pend_v_q[scan_q] && (!full || pop);
    push_dir = pend_dir_q[scan_q];
    scan_d   = (scan_q == LAST_IDX) ? '0 : scan_q + IDX_W'(1);
  end

  // Pending update: consumption by the scanner is applied before a new edge,
  // so an edge landing on the consumed switch re-arms it instead of cancelling
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      if (push && (scan_q == IDX_W'(i))) begin
        pend_v_d[i] = 1'b0;
      end
      if (rise[i] || fall[i]) begin
        if (pend_v_d[i]) begin
          pend_v_d[i] = 1'b0;
        end else begin
          pend_v_d[i]   = 1'b1;
          pend_dir_d[i] = rise[i];
        end
      end
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  // Up count / first-up follow pushed events, not pops
  always_comb begin
    up_cnt_d = up_cnt_q;
    first_d  = first_q;
    if (push) begin
      if (push_dir) begin
        up_cnt_d = up_cnt_q + CNT_W'(1);
        if (first_q == NONE) begin
          first_d = scan_q;
        end
      end else begin
        if (up_cnt_q != '0) begin
          up_cnt_d = up_cnt_q - CNT_W'(1);
        end
        if ((scan_q == first_q) || (up_cnt_d == '0)) begin
          first_d = NONE;
        end
      end
    end
  end

  // Popcount of the switch bus, used to seed the up count at reset
  always_comb begin
    sw_pop = '0;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      sw_pop = sw_pop + CNT_W'(SW[i]);
    end
  end

  // State registers; reset seeds history from SW so held switches give no events
  always_ff @(posedge CLK) begin
    hist_q <= SW;
    if (RESET) begin
      pend_v_q   <= '0;
      pend_dir_q <= '0;
      scan_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      up_cnt_q   <= sw_pop;
      first_q    <= NONE;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
      scan_q     <= scan_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      up_cnt_q   <= up_cnt_d;
      first_q    <= first_d;
    end
  end

  // FIFO storage write
  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      mem_q[wr_ptr_q] <= {scan_q, push_dir};
    end
  end

  // Output drive; head fields read as zero while the FIFO is empty
  always_comb begin
    head      = mem_q[rd_ptr_q];
    EVT_VALID = (count_q != '0);
    EVT_IDX   = EVT_VALID ? head[IDX_W:1] : '0;
    EVT_DIR   = EVT_VALID ? head[0] : 1'b0;
    UP_COUNT  = up_cnt_q;
    FIRST_UP  = first_q;
    CONFLICT  = (up_cnt_q > CNT_W'(1));
    SCAN_IDX  = scan_q;
  end

endmodule

// File: tb/tb_switch_event_scanner.sv
// Testbench for switch_event_scanner: directed scenarios plus a randomized
// run against a level-based reference model.
module tb_switch_event_scanner;

  localparam int NUM_SW     = 10;
  localparam int IDX_W      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 4;
  localparam logic [IDX_W-1:0] NONE = '1;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [NUM_SW-1:0] SW = '0;
  logic              EVT_READY = 1'b0;
  logic              EVT_VALID;
  logic [IDX_W-1:0]  EVT_IDX;
  logic              EVT_DIR;
  logic [CNT_W-1:0]  UP_COUNT;
  logic [IDX_W-1:0]  FIRST_UP;
  logic              CONFLICT;
  logic [IDX_W-1:0]  SCAN_IDX;

  int n_tests = 0;
  int n_fail  = 0;

  switch_event_scanner #(
    .NUM_SW(NUM_SW), .IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .SW(SW),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
    .EVT_IDX(EVT_IDX), .EVT_DIR(EVT_DIR),
    .UP_COUNT(UP_COUNT), .FIRST_UP(FIRST_UP),
    .CONFLICT(CONFLICT), .SCAN_IDX(SCAN_IDX)
  );

  always #5 CLK = ~CLK;

  // Reference model: a switch has an event owed whenever its level sampled at
  // the previous edge differs from the last level it reported.
  logic [NUM_SW-1:0] m_hist = '0;
  logic [NUM_SW-1:0] m_rep  = '0;
  int unsigned       m_scan = 0;
  logic [IDX_W:0]    m_q[$];
  logic [IDX_W:0]    m_log[$];
  logic [IDX_W-1:0]  m_first = '1;
  bit                m_pop, m_can;
  logic              m_lvl;

  always @(posedge CLK) begin
    if (RESET) begin
      m_hist  = SW;
      m_rep   = SW;
      m_q.delete();
      m_log.delete();
      m_scan  = 0;
      m_first = NONE;
    end else begin
      m_pop = (m_q.size() != 0) && EVT_READY;
      m_can = (m_q.size() < FIFO_DEPTH) || m_pop;
      if (m_pop) void'(m_q.pop_front());
      m_lvl = m_hist[m_scan];
      if ((m_lvl != m_rep[m_scan]) && m_can) begin
        m_q.push_back({IDX_W'(m_scan), m_lvl});
        m_log.push_back({IDX_W'(m_scan), m_lvl});
        m_rep[m_scan] = m_lvl;
        if (m_lvl) begin
          if (m_first == NONE) m_first = IDX_W'(m_scan);
        end else begin
          if ((IDX_W'(m_scan) == m_first) || ($countones(m_rep) == 0)) m_first = NONE;
        end
      end
      m_hist = SW;
      m_scan = (m_scan + 1) % NUM_SW;
    end
  end

  logic [IDX_W:0] obs[$];

  // Record the head if it will be accepted at the coming edge, then advance.
  task automatic step_collect();
    if (EVT_VALID && EVT_READY) obs.push_back({EVT_IDX, EVT_DIR});
    @(negedge CLK);
  endtask

  task automatic apply_reset(input logic [NUM_SW-1:0] sw);
    @(negedge CLK);
    SW = sw;
    RESET = 1'b1;
    EVT_READY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    apply_reset(10'b0000000101);
    n_tests++; if (UP_COUNT !== 4'd2) begin n_fail++; $display("FAIL reset_upcount: got %0d expected 2", UP_COUNT); end
    n_tests++; if (FIRST_UP !== 4'hF) begin n_fail++; $display("FAIL reset_firstup: got %0h expected f", FIRST_UP); end
    n_tests++; if (CONFLICT !== 1'b1) begin n_fail++; $display("FAIL reset_conflict: got %0b expected 1", CONFLICT); end
    n_tests++; if ({EVT_VALID, EVT_IDX, EVT_DIR} !== 6'd0) begin n_fail++; $display("FAIL reset_head: got %0b/%0h/%0b expected 0/0/0", EVT_VALID, EVT_IDX, EVT_DIR); end
    n_tests++; if (SCAN_IDX !== 4'd0) begin n_fail++; $display("FAIL reset_scan: got %0d expected 0", SCAN_IDX); end
    seen = 0;
    for (int c = 0; c < 3 * NUM_SW; c++) begin
      @(negedge CLK);
      if (EVT_VALID) seen = 1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_events: got valid=%0b expected 0", seen); end
  endtask

  task automatic test_single_up();
    int cycles;
    apply_reset('0);
    SW[3] = 1'b1;
    cycles = 0;
    while (!EVT_VALID && cycles < 20) begin
      @(negedge CLK);
      cycles++;
    end
    n_tests++; if (EVT_VALID !== 1'b1 || cycles > NUM_SW + 1) begin n_fail++; $display("FAIL single_latency: got valid=%0b after %0d cycles expected 1 within %0d", EVT_VALID, cycles, NUM_SW + 1); end
    n_tests++; if ({EVT_IDX, EVT_DIR} !== {4'd3, 1'b1}) begin n_fail++; $display("FAIL single_event: got %0d/%0b expected 3/1", EVT_IDX, EVT_DIR); end
    n_tests++; if (UP_COUNT !== 4'd1) begin n_fail++; $display("FAIL single_upcount: got %0d expected 1", UP_COUNT); end
    n_tests++; if (FIRST_UP !== 4'd3) begin n_fail++; $display("FAIL single_firstup: got %0h expected 3", FIRST_UP); end
    n_tests++; if (CONFLICT !== 1'b0) begin n_fail++; $display("FAIL single_conflict: got %0b expected 0", CONFLICT); end
    EVT_READY = 1'b1;
    @(negedge CLK);
    EVT_READY = 1'b0;
    n_tests++; if (EVT_VALID !== 1'b0) begin n_fail++; $display("FAIL single_pop: got valid=%0b expected 0", EVT_VALID); end
  endtask

  task automatic test_order_firstup();
    logic [IDX_W:0] e0, e1, e2;
    logic [IDX_W-1:0] fidx;
    apply_reset('0);
    EVT_READY = 1'b1;
    obs.delete();
    SW[7] = 1'b1;
    step_collect();
    SW[2] = 1'b1;
    for (int c = 0; c < 30; c++) step_collect();
    n_tests++; if (obs.size() != 2) begin n_fail++; $display("FAIL order_count: got %0d expected 2", obs.size()); end
    if (obs.size() >= 2) begin
      e0 = obs[0]; e1 = obs[1];
      n_tests++; if (e0 !== 5'b0010_1 || e1 !== 5'b0111_1) begin n_fail++; $display("FAIL order_seq: got %0h,%0h expected 5,f", e0, e1); end
      n_tests++; if (e0 !== m_log[0] || e1 !== m_log[1]) begin n_fail++; $display("FAIL order_model: got %0h,%0h expected %0h,%0h", e0, e1, m_log[0], m_log[1]); end
      fidx = e0[IDX_W:1];
      n_tests++; if (FIRST_UP !== fidx) begin n_fail++; $display("FAIL order_firstup: got %0h expected %0h", FIRST_UP, fidx); end
      n_tests++; if (UP_COUNT !== 4'd2 || CONFLICT !== 1'b1) begin n_fail++; $display("FAIL order_conflict: got %0d/%0b expected 2/1", UP_COUNT, CONFLICT); end
      SW[fidx] = 1'b0;
      for (int c = 0; c < 25; c++) step_collect();
      n_tests++; if (obs.size() != 3) begin n_fail++; $display("FAIL drop_count: got %0d expected 3", obs.size()); end
      if (obs.size() >= 3) begin
        e2 = obs[2];
        n_tests++; if (e2 !== {fidx, 1'b0}) begin n_fail++; $display("FAIL drop_event: got %0h expected %0h", e2, {fidx, 1'b0}); end
      end
      n_tests++; if (FIRST_UP !== NONE) begin n_fail++; $display("FAIL drop_firstup: got %0h expected f", FIRST_UP); end
      n_tests++; if (UP_COUNT !== 4'd1 || CONFLICT !== 1'b0) begin n_fail++; $display("FAIL drop_count_conflict: got %0d/%0b expected 1/0", UP_COUNT, CONFLICT); end
    end
  endtask

  task automatic test_pulse();
    int guard;
    logic [IDX_W:0] e0, e1;
    apply_reset('0);
    EVT_READY = 1'b1;
    obs.delete();
    guard = 0;
    while (m_scan != 0 && guard < 30) begin @(negedge CLK); guard++; end
    SW[5] = 1'b1;
    step_collect();
    SW[5] = 1'b0;
    for (int c = 0; c < 2 * NUM_SW; c++) step_collect();
    n_tests++; if (obs.size() != 0 || UP_COUNT !== 4'd0) begin n_fail++; $display("FAIL pulse_away: got %0d events upcount %0d expected 0/0", obs.size(), UP_COUNT); end
    guard = 0;
    while (m_scan != 4 && guard < 30) begin @(negedge CLK); guard++; end
    SW[5] = 1'b1;
    step_collect();
    SW[5] = 1'b0;
    for (int c = 0; c < 2 * NUM_SW + 2; c++) step_collect();
    n_tests++; if (obs.size() != 2) begin n_fail++; $display("FAIL pulse_scan_count: got %0d expected 2", obs.size()); end
    if (obs.size() >= 2) begin
      e0 = obs[0]; e1 = obs[1];
      n_tests++; if (e0 !== {4'd5, 1'b1} || e1 !== {4'd5, 1'b0}) begin n_fail++; $display("FAIL pulse_scan_seq: got %0h,%0h expected b,a", e0, e1); end
    end
    n_tests++; if (UP_COUNT !== 4'd0) begin n_fail++; $display("FAIL pulse_upcount: got %0d expected 0", UP_COUNT); end
  endtask

  task automatic test_backpressure();
    logic [IDX_W:0] h, e;
    logic [IDX_W-1:0] a, b;
    int guard, ups, downs;
    apply_reset('0);
    obs.delete();
    SW = '1;
    for (int c = 0; c < 2 * NUM_SW; c++) @(negedge CLK);
    n_tests++; if (EVT_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b expected 1", EVT_VALID); end
    h = {EVT_IDX, EVT_DIR};
    for (int c = 0; c < 5; c++) @(negedge CLK);
    n_tests++; if ({EVT_IDX, EVT_DIR} !== h || h !== m_log[0]) begin n_fail++; $display("FAIL bp_head_stable: got %0h expected %0h", {EVT_IDX, EVT_DIR}, m_log[0]); end
    e = m_log[0]; a = e[IDX_W:1];
    e = m_log[1]; b = e[IDX_W:1];
    SW[a] = 1'b0;
    @(negedge CLK);
    SW[b] = 1'b0;
    @(negedge CLK);
    EVT_READY = 1'b1;
    guard = 0;
    while (obs.size() < 12 && guard < 300) begin step_collect(); guard++; end
    for (int c = 0; c < 2 * NUM_SW; c++) step_collect();
    n_tests++; if (obs.size() != 12) begin n_fail++; $display("FAIL bp_total: got %0d expected 12", obs.size()); end
    ups = 0; downs = 0;
    for (int i = 0; i < obs.size(); i++) begin
      e = obs[i];
      if (e[0]) ups++; else downs++;
      n_tests++;
      if (i >= m_log.size() || e !== m_log[i]) begin
        n_fail++; $display("FAIL bp_event_%0d: got %0h expected %0h", i, e, (i < m_log.size()) ? m_log[i] : 5'h1f);
      end
    end
    n_tests++; if (ups != 10 || downs != 2) begin n_fail++; $display("FAIL bp_dirs: got %0d up %0d down expected 10/2", ups, downs); end
    n_tests++; if (UP_COUNT !== CNT_W'($countones(SW)) || UP_COUNT !== 4'd8) begin n_fail++; $display("FAIL bp_upcount: got %0d expected 8", UP_COUNT); end
  endtask

  task automatic test_reset_midop();
    bit seen;
    apply_reset('0);
    SW = 10'b0100010001;
    for (int c = 0; c < 2 * NUM_SW; c++) @(negedge CLK);
    n_tests++; if (EVT_VALID !== 1'b1) begin n_fail++; $display("FAIL midreset_queued: got %0b expected 1", EVT_VALID); end
    SW = 10'b0000000011;
    RESET = 1'b1;
    @(negedge CLK);
    n_tests++; if (EVT_VALID !== 1'b0) begin n_fail++; $display("FAIL midreset_empty: got %0b expected 0", EVT_VALID); end
    n_tests++; if (UP_COUNT !== 4'd2 || FIRST_UP !== NONE || CONFLICT !== 1'b1) begin n_fail++; $display("FAIL midreset_track: got %0d/%0h/%0b expected 2/f/1", UP_COUNT, FIRST_UP, CONFLICT); end
    RESET = 1'b0;
    EVT_READY = 1'b1;
    seen = 0;
    for (int c = 0; c < 3 * NUM_SW; c++) begin
      @(negedge CLK);
      if (EVT_VALID) seen = 1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_stale: got valid=%0b expected 0", seen); end
  endtask

  task automatic test_random();
    logic [IDX_W:0] exp_head;
    int unsigned pc;
    apply_reset(NUM_SW'($urandom));
    for (int cyc = 0; cyc < 4000; cyc++) begin
      pc = $countones(m_rep);
      n_tests++; if (EVT_VALID !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", cyc, EVT_VALID, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        exp_head = m_q[0];
        n_tests++; if ({EVT_IDX, EVT_DIR} !== exp_head) begin n_fail++; $display("FAIL rnd_head@%0d: got %0h expected %0h", cyc, {EVT_IDX, EVT_DIR}, exp_head); end
      end
      n_tests++; if (UP_COUNT !== CNT_W'(pc)) begin n_fail++; $display("FAIL rnd_upcount@%0d: got %0d expected %0d", cyc, UP_COUNT, pc); end
      n_tests++; if (FIRST_UP !== m_first) begin n_fail++; $display("FAIL rnd_firstup@%0d: got %0h expected %0h", cyc, FIRST_UP, m_first); end
      n_tests++; if (CONFLICT !== (pc > 1)) begin n_fail++; $display("FAIL rnd_conflict@%0d: got %0b expected %0b", cyc, CONFLICT, pc > 1); end
      n_tests++; if (SCAN_IDX !== IDX_W'(m_scan)) begin n_fail++; $display("FAIL rnd_scan@%0d: got %0d expected %0d", cyc, SCAN_IDX, m_scan); end
      for (int i = 0; i < NUM_SW; i++) begin
        if ($urandom_range(0, 15) == 0) SW[i] = ~SW[i];
      end
      if ((cyc % 200) < 70) EVT_READY = ($urandom_range(0, 3) == 0);
      else                  EVT_READY = ($urandom_range(0, 3) != 0);
      RESET = (cyc == 2000);
      @(negedge CLK);
    end
    RESET = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_up();
    test_order_firstup();
    test_pulse();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
